uart_tx_jogo: RTL and testbench

//  Game-to-PC serial transmitter. Consumes the uart_macro/uart_micro/uart_estado and

---
 rtl/uart_tx_jogo_pkg.sv | 31 +++
 rtl/uart_tx_jogo_if.sv | 23 ++
 rtl/uart_tx_serial.sv | 75 +++++++
 rtl/uart_tx_jogo.sv | 121 ++++++++++++
 tb/tb_uart_tx_jogo.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_jogo_pkg.sv
// Frame constants, sequencer state codes and ASCII helpers shared by the game UART transmitter.
// Latency and backpressure: none. This package holds no logic.
package uart_tx_jogo_pkg;

    localparam logic [7:0] CAB       = 8'h23;
    localparam logic [7:0] FIM       = 8'h0A;
    localparam int         FRAME_LEN = 7;

    localparam logic [2:0] ST_OCIOSO  = 3'd0;
    localparam logic [2:0] ST_CARREGA = 3'd1;
    localparam logic [2:0] ST_ENVIA   = 3'd2;
    localparam logic [2:0] ST_ESPERA  = 3'd3;
    localparam logic [2:0] ST_FIM     = 3'd4;

    typedef struct packed {
        logic [3:0] macro;
        logic [3:0] micro;
        logic [3:0] estado;
        logic [1:0] res_macro;
        logic [1:0] res_jogo;
    } snapshot_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        return (v < 4'd10) ? 8'h30 + {4'h0, v} : 8'h37 + {4'h0, v};
    endfunction

    function automatic logic [7:0] res_ascii(input logic [1:0] v);
        return 8'h30 + {6'h0, v};
    endfunction

endpackage

// File: rtl/uart_tx_jogo_if.sv
// Game-state snapshot inputs, frame request and serial status between the game core and the transmitter.
// Latency and backpressure: none. The interface carries signals only, and enviar is a level request.
interface uart_tx_jogo_if;
    logic       enviar;
    logic [3:0] macro;
    logic [3:0] micro;
    logic [3:0] estado;
    logic [1:0] resultado_macro;
    logic [1:0] resultado_jogo;
    logic       tx;
    logic       ocupado;
    logic       pronto;

    modport master (
        output enviar, macro, micro, estado, resultado_macro, resultado_jogo,
        input  tx, ocupado, pronto
    );

    modport slave (
        input  enviar, macro, micro, estado, resultado_macro, resultado_jogo,
        output tx, ocupado, pronto
    );
endinterface

// File: rtl/uart_tx_serial.sv
// 8N1 byte serializer: partida loads a byte and tx drops to the start bit on the next cycle. Each bit lasts CLKS_PER_BIT cycles.
// Backpressure: partida is ignored while busy, except during the last stop-bit cycle (fim), where it chains the next byte with no gap.
module uart_tx_serial #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dado,
    output logic       tx,
    output logic       ocupado,
    output logic       fim
);
    localparam int            CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          ultimo;

    assign ultimo = busy_q && (bit_q == 4'd9) && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        if (partida && (!busy_q || ultimo)) begin
            shift_d = {1'b1, dado, 1'b0};
            cnt_d   = '0;
            bit_d   = 4'd0;
            busy_d  = 1'b1;
            tx_d    = 1'b0;
        end else if (busy_q) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                if (bit_q == 4'd9) begin
                    busy_d = 1'b0;
                    tx_d   = 1'b1;
                end else begin
                    // shift_q[1] is the next bit on the line (data LSB first, then stop)
                    bit_d   = bit_q + 4'd1;
                    shift_d = {1'b1, shift_q[9:1]};
                    tx_d    = shift_q[1];
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            shift_q <= '1;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx      = tx_q;
    assign ocupado = busy_q;
    assign fim     = ultimo;
endmodule

// File: rtl/uart_tx_jogo.sv
// Snapshots the game buses on request and sends '#',macro,micro,estado,res_macro,res_jogo,'\n' as one 7-byte frame.
// Latency and backpressure: the start bit follows acceptance by 1 cycle. A request during a frame sets a single pendente flag, and that frame then follows with one idle cycle.
module uart_tx_jogo
    import uart_tx_jogo_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input logic           clock,
    input logic           reset,
    uart_tx_jogo_if.slave bus
);
    localparam logic [2:0] ULTIMO_IDX = 3'(FRAME_LEN - 1);

    logic [2:0] st_q, st_d;
    logic [2:0] idx_q, idx_d;
    logic       pendente_q, pendente_d;
    snapshot_t  snap_q, snap_d;
    snapshot_t  entrada;

    logic       partida;
    logic [2:0] sel;
    logic [7:0] dado;
    logic       ser_tx;
    logic       ser_ocupado;
    logic       ser_fim;

    assign entrada = {bus.macro, bus.micro, bus.estado, bus.resultado_macro, bus.resultado_jogo};

    always_comb begin
        st_d       = st_q;
        idx_d      = idx_q;
        pendente_d = pendente_q;
        snap_d     = snap_q;
        partida    = 1'b0;
        sel        = 3'd0;
        case (st_q)
            ST_OCIOSO: begin
                if (bus.enviar) begin
                    snap_d = entrada;
                    idx_d  = 3'd0;
                    st_d   = ST_CARREGA;
                end
            end
            ST_CARREGA: begin
                partida = 1'b1;
                st_d    = ST_ENVIA;
                if (bus.enviar) pendente_d = 1'b1;
            end
            ST_ENVIA: begin
                if (bus.enviar) pendente_d = 1'b1;
                // next byte is handed over during the stop bit's last cycle so bytes abut
                if (ser_fim) begin
                    partida = 1'b1;
                    sel     = idx_q + 3'd1;
                    idx_d   = sel;
                    if (sel == ULTIMO_IDX) st_d = ST_ESPERA;
                end
            end
            ST_ESPERA: begin
                if (bus.enviar) pendente_d = 1'b1;
                if (ser_fim) st_d = ST_FIM;
            end
            ST_FIM: begin
                if (pendente_q) begin
                    // header byte is constant, so it can start while the snapshot is re-taken
                    snap_d     = entrada;
                    idx_d      = 3'd0;
                    pendente_d = 1'b0;
                    partida    = 1'b1;
                    st_d       = ST_ENVIA;
                end else begin
                    st_d = ST_OCIOSO;
                end
            end
            default: st_d = ST_OCIOSO;
        endcase
    end

    always_comb begin
        case (sel)
            3'd0:    dado = CAB;
            3'd1:    dado = hex_ascii(snap_q.macro);
            3'd2:    dado = hex_ascii(snap_q.micro);
            3'd3:    dado = hex_ascii(snap_q.estado);
            3'd4:    dado = res_ascii(snap_q.res_macro);
            3'd5:    dado = res_ascii(snap_q.res_jogo);
            default: dado = FIM;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st_q       <= ST_OCIOSO;
            idx_q      <= 3'd0;
            pendente_q <= 1'b0;
            snap_q     <= '0;
        end else begin
            st_q       <= st_d;
            idx_q      <= idx_d;
            pendente_q <= pendente_d;
            snap_q     <= snap_d;
        end
    end

    uart_tx_serial #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_serial (
        .clock   (clock),
        .reset   (reset),
        .partida (partida),
        .dado    (dado),
        .tx      (ser_tx),
        .ocupado (ser_ocupado),
        .fim     (ser_fim)
    );

    assign bus.tx      = ser_tx;
    assign bus.pronto  = (st_q == ST_FIM);
    assign bus.ocupado = ser_ocupado || (st_q == ST_CARREGA) || (st_q == ST_ENVIA) ||
                         (st_q == ST_ESPERA) || ((st_q == ST_FIM) && pendente_q);
endmodule

// File: tb/tb_uart_tx_jogo.sv
// Directed bench for uart_tx_jogo at 4 clocks per bit. A mid-bit sampling receiver is checked against hand-built frames.
module tb_uart_tx_jogo;
    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic [7:0] rx_b [14];
    int         rx_s [14];

    uart_tx_jogo_if bus ();

    uart_tx_jogo #(.CLKS_PER_BIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic [3:0] m, input logic [3:0] mi, input logic [3:0] e,
                          input logic [1:0] rm, input logic [1:0] rj);
        bus.macro           = m;
        bus.micro           = mi;
        bus.estado          = e;
        bus.resultado_macro = rm;
        bus.resultado_jogo  = rj;
    endtask

    task automatic rx_bytes(input int n);
        int w;
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (bus.tx !== 1'b0 && w < 400) begin
                tick(1);
                w++;
            end
            rx_s[k] = cyc;
            tick(2);
            check("rx_start_bit", 32'(bus.tx), 32'd0);
            for (int b = 0; b < 8; b++) begin
                tick(4);
                rx_b[k][b] = bus.tx;
            end
            tick(4);
            check("rx_stop_bit", 32'(bus.tx), 32'd1);
        end
    endtask

    task automatic check_frame(input string tag, input int base, input logic [55:0] exp);
        for (int j = 0; j < 7; j++)
            check($sformatf("%s_byte%0d", tag, j), 32'(rx_b[base+j]), 32'(exp[55-8*j -: 8]));
    endtask

    task automatic send_one(input string tag, input logic [3:0] m, input logic [3:0] mi,
                            input logic [3:0] e, input logic [1:0] rm, input logic [1:0] rj,
                            input logic [55:0] exp, input bit scramble);
        int n0;
        set_in(m, mi, e, rm, rj);
        bus.enviar = 1'b1;
        tick(1);
        bus.enviar = 1'b0;
        n0 = cyc;
        if (scramble) set_in(~m, ~mi, ~e, ~rm, ~rj);
        fork
            rx_bytes(7);
            begin
                int rel;
                check({tag, "_tx_at_accept"}, 32'(bus.tx), 32'd1);
                for (int i = 0; i < 290; i++) begin
                    tick(1);
                    rel = cyc - n0;
                    if (rel == 1) begin
                        check({tag, "_start_low"}, 32'(bus.tx), 32'd0);
                        check({tag, "_busy"}, 32'(bus.ocupado), 32'd1);
                    end
                    if (rel == 280) check({tag, "_pronto_early"}, 32'(bus.pronto), 32'd0);
                    if (rel == 281) begin
                        check({tag, "_pronto"}, 32'(bus.pronto), 32'd1);
                        check({tag, "_idle_at_end"}, 32'(bus.ocupado), 32'd0);
                        check({tag, "_tx_at_end"}, 32'(bus.tx), 32'd1);
                    end
                    if (rel == 282) check({tag, "_pronto_width"}, 32'(bus.pronto), 32'd0);
                end
            end
        join
        check({tag, "_first_start"}, rx_s[0] - n0, 1);
        check({tag, "_contiguous"}, rx_s[6] - rx_s[0], 240);
        check_frame(tag, 0, exp);
    endtask

    initial begin
        int n0;
        int hi_cnt;
        int oc_cnt;
        int pr_cnt;
        int np;
        int p1;
        int p2;
        int rel;

        reset = 1'b1;
        bus.enviar = 1'b0;
        set_in(4'h0, 4'h0, 4'h0, 2'd0, 2'd0);
        tick(3);
        check("rst_tx", 32'(bus.tx), 32'd1);
        check("rst_ocupado", 32'(bus.ocupado), 32'd0);
        check("rst_pronto", 32'(bus.pronto), 32'd0);
        reset = 1'b0;

        hi_cnt = 0; oc_cnt = 0; pr_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            hi_cnt += int'(bus.tx === 1'b1);
            oc_cnt += int'(bus.ocupado !== 1'b0);
            pr_cnt += int'(bus.pronto !== 1'b0);
        end
        check("idle_tx_high", hi_cnt, 100);
        check("idle_ocupado", oc_cnt, 0);
        check("idle_pronto", pr_cnt, 0);

        send_one("basic", 4'h4, 4'hB, 4'h7, 2'd1, 2'd2, 56'h23_34_42_37_31_32_0A, 1'b0);
        tick(5);

        send_one("snapshot", 4'h2, 4'h8, 4'hC, 2'd0, 2'd3, 56'h23_32_38_43_30_33_0A, 1'b1);
        tick(5);

        // three requests inside one frame collapse into one chained frame
        set_in(4'h1, 4'h0, 4'h9, 2'd2, 2'd0);
        bus.enviar = 1'b1;
        tick(1);
        bus.enviar = 1'b0;
        n0 = cyc;
        np = 0; p1 = -1; p2 = -1;
        fork
            rx_bytes(14);
            for (int i = 0; i < 640; i++) begin
                tick(1);
                rel = cyc - n0;
                if (bus.pronto === 1'b1) begin
                    np++;
                    if (np == 1) p1 = rel;
                    else p2 = rel;
                end
                bus.enviar = (rel == 50 || rel == 100 || rel == 150);
                if (rel == 200) set_in(4'h8, 4'h5, 4'hA, 2'd3, 2'd1);
            end
        join
        check("pend_pronto_count", np, 2);
        check("pend_pronto1", p1, 281);
        check("pend_pronto2", p2, 562);
        check("pend_restart", rx_s[7] - n0, 282);
        check("pend_frame2_contig", rx_s[13] - rx_s[7], 240);
        check_frame("pend_f1", 0, 56'h23_31_30_39_32_30_0A);
        check_frame("pend_f2", 7, 56'h23_38_35_41_33_31_0A);
        check("pend_no_third", 32'(bus.ocupado), 32'd0);
        tick(5);

        // abort during data bit 3 (a zero) of byte 3
        set_in(4'h4, 4'hB, 4'h7, 2'd1, 2'd2);
        bus.enviar = 1'b1;
        tick(1);
        bus.enviar = 1'b0;
        n0 = cyc;
        for (int i = 0; i < 200 && (cyc - n0) < 137; i++) tick(1);
        check("abort_pre_tx", 32'(bus.tx), 32'd0);
        reset = 1'b1;
        tick(1);
        check("abort_tx", 32'(bus.tx), 32'd1);
        check("abort_ocupado", 32'(bus.ocupado), 32'd0);
        check("abort_pronto", 32'(bus.pronto), 32'd0);
        reset = 1'b0;
        hi_cnt = 0; oc_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            hi_cnt += int'(bus.tx === 1'b1);
            oc_cnt += int'(bus.ocupado !== 1'b0);
        end
        check("abort_quiet_tx", hi_cnt, 60);
        check("abort_quiet_ocupado", oc_cnt, 0);
        send_one("after_abort", 4'h4, 4'hB, 4'h7, 2'd1, 2'd2, 56'h23_34_42_37_31_32_0A, 1'b0);
        tick(5);

        send_one("boundary", 4'h0, 4'h9, 4'hF, 2'd3, 2'd3, 56'h23_30_39_46_33_33_0A, 1'b0);
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
